// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 BIST sequencer.
package c17_bist_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      APPLY   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } bist_state_t;

   // LFSR feedback is pat[4] ^ pat[LFSR_TAP]  (x^5 + x^3 + 1)
   localparam int unsigned LFSR_TAP = 2;

   localparam logic [15:0] MISR_POLY = 16'h1021;

   // Position of each c17 input pin within pat
   localparam int unsigned PAT_G1 = 4;
   localparam int unsigned PAT_G2 = 3;
   localparam int unsigned PAT_G3 = 2;
   localparam int unsigned PAT_G6 = 1;
   localparam int unsigned PAT_G7 = 0;

endpackage

// File: rtl/c17_bist_misr.sv
// 16-bit multiple-input signature register compacting the 2-bit c17 response.
module c17_bist_misr
   import c17_bist_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [1:0]  din,
   output logic [15:0] sig,
   output logic [15:0] sig_nxt
);

   always_comb begin
      sig_nxt = {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : '0) ^ {14'b0, din};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sig <= '0;
      else if (clr)
         sig <= '0;
      else if (en)
         sig <= sig_nxt;
   end

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST sequencer: LFSR pattern source, settle/capture FSM and MISR signature check.
module c17_bist_ctrl
   import c17_bist_pkg::*;
#(
   parameter int unsigned NUM_PATTERNS  = 31,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter logic [4:0]  LFSR_SEED     = 5'b00001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] golden_sig,
   input  logic [1:0]  resp,
   output logic [4:0]  pat,
   output logic        cut_sel,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] sig
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [7:0] NUM_LAST    = 8'(NUM_PATTERNS);

   bist_state_t state, state_nxt;
   logic [7:0]  pcnt;
   logic [3:0]  scnt;
   logic [15:0] sig_nxt;
   logic        ld, cap, fin, clr_flags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // done/pass are flags rather than state decodes: abort+start in DONE
   // keeps the state but must still drop done.
   always_comb begin
      state_nxt = state;
      ld        = 1'b0;
      cap       = 1'b0;
      fin       = 1'b0;
      clr_flags = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (abort) begin
               clr_flags = 1'b1;
            end else if (start) begin
               ld        = 1'b1;
               state_nxt = APPLY;
            end
         end
         APPLY: begin
            if (abort) begin
               clr_flags = 1'b1;
               state_nxt = IDLE;
            end else if (scnt == SETTLE_LAST) begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            if (abort) begin
               clr_flags = 1'b1;
               state_nxt = IDLE;
            end else begin
               cap = 1'b1;
               if (pcnt + 8'd1 == NUM_LAST) begin
                  fin       = 1'b1;
                  state_nxt = DONE;
               end else begin
                  state_nxt = APPLY;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat  <= LFSR_SEED;
         pcnt <= '0;
         scnt <= '0;
         done <= 1'b0;
         pass <= 1'b0;
      end else begin
         if (ld) begin
            pat  <= LFSR_SEED;
            pcnt <= '0;
            scnt <= '0;
            done <= 1'b0;
            pass <= 1'b0;
         end
         if (clr_flags) begin
            done <= 1'b0;
            pass <= 1'b0;
         end
         if (state == APPLY && !abort)
            scnt <= scnt + 4'd1;
         if (cap) begin
            pat  <= {pat[3:0], pat[4] ^ pat[LFSR_TAP]};
            pcnt <= pcnt + 8'd1;
            scnt <= '0;
         end
         if (fin) begin
            done <= 1'b1;
            pass <= (sig_nxt == golden_sig);
         end
      end
   end

   c17_bist_misr u_misr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (ld),
      .en      (cap),
      .din     (resp),
      .sig     (sig),
      .sig_nxt (sig_nxt)
   );

   always_comb begin
      busy    = (state == APPLY) || (state == CAPTURE);
      cut_sel = busy;
   end

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Directed bench: short run (3 patterns), full-period run (31 patterns), abort and contention cases.
module tb_c17_bist_ctrl;
   import c17_bist_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // short-run instance
   logic        s_start, s_abort, s_cut, s_busy, s_done, s_pass;
   logic [15:0] s_gold, s_sig;
   logic [1:0]  s_resp;
   logic [4:0]  s_pat;
   // full-period instance
   logic        w_start, w_abort, w_cut, w_busy, w_done, w_pass;
   logic [15:0] w_gold, w_sig;
   logic [1:0]  w_resp;
   logic [4:0]  w_pat;

   function automatic logic [1:0] c17(input logic [4:0] p);
      logic g10, g11, g16, g19;
      g10 = ~(p[PAT_G1] & p[PAT_G3]);
      g11 = ~(p[PAT_G3] & p[PAT_G6]);
      g16 = ~(p[PAT_G2] & g11);
      g19 = ~(g11 & p[PAT_G7]);
      return {~(g16 & g19), ~(g10 & g16)};
   endfunction

   assign s_resp = c17(s_pat);
   assign w_resp = c17(w_pat);

   c17_bist_ctrl #(.NUM_PATTERNS(3), .SETTLE_CYCLES(1), .LFSR_SEED(5'b00001)) u_short (
      .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .golden_sig(s_gold),
      .resp(s_resp), .pat(s_pat), .cut_sel(s_cut), .busy(s_busy), .done(s_done),
      .pass(s_pass), .sig(s_sig)
   );

   c17_bist_ctrl #(.NUM_PATTERNS(31), .SETTLE_CYCLES(2), .LFSR_SEED(5'b00001)) u_wrap (
      .clk(clk), .rst_n(rst_n), .start(w_start), .abort(w_abort), .golden_sig(w_gold),
      .resp(w_resp), .pat(w_pat), .cut_sel(w_cut), .busy(w_busy), .done(w_done),
      .pass(w_pass), .sig(w_sig)
   );

   // {pat, sig, busy, cut_sel, done, pass}
   localparam logic [24:0] RST_VEC = {5'b00001, 16'h0000, 4'b0000};

   task automatic test_reset();
      rst_n = 1'b0;
      s_start = 1'b0; s_abort = 1'b0; s_gold = 16'h0008;
      w_start = 1'b0; w_abort = 1'b0; w_gold = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({s_pat, s_sig, s_busy, s_cut, s_done, s_pass} !== RST_VEC) begin
         bad++;
         $display("FAIL reset_short got=%h exp=%h", {s_pat, s_sig, s_busy, s_cut, s_done, s_pass}, RST_VEC);
      end
      total++;
      if ({w_pat, w_sig, w_busy, w_cut, w_done, w_pass} !== RST_VEC) begin
         bad++;
         $display("FAIL reset_wrap got=%h exp=%h", {w_pat, w_sig, w_busy, w_cut, w_done, w_pass}, RST_VEC);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_short(input logic [15:0] gold, input logic exp_pass);
      logic [4:0] ep [3];
      ep[0] = 5'b00001; ep[1] = 5'b00010; ep[2] = 5'b00100;
      s_gold  = gold;
      s_start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         s_start = 1'b0;
         total++;
         if ({s_busy, s_cut, s_pat} !== {2'b11, ep[i/2]}) begin
            bad++;
            $display("FAIL short_cycle%0d busy,cut,pat got=%b exp=%b", i, {s_busy, s_cut, s_pat}, {2'b11, ep[i/2]});
         end
         if (i == 0) begin
            total++;
            if (s_sig !== 16'h0000) begin
               bad++;
               $display("FAIL short_first_sig got=%h exp=0000", s_sig);
            end
         end
      end
      @(negedge clk);
      total++;
      if ({s_busy, s_cut, s_done, s_pass, s_sig, s_pat} !== {3'b001, exp_pass, 16'h0008, 5'b01001}) begin
         bad++;
         $display("FAIL short_done busy,cut,done,pass,sig,pat got=%h exp=%h",
                  {s_busy, s_cut, s_done, s_pass, s_sig, s_pat}, {3'b001, exp_pass, 16'h0008, 5'b01001});
      end
      // pass must not track golden after DONE entry
      s_gold = ~gold;
      repeat (2) @(negedge clk);
      total++;
      if ({s_done, s_pass} !== {1'b1, exp_pass}) begin
         bad++;
         $display("FAIL short_golden_late done,pass got=%b exp=%b", {s_done, s_pass}, {1'b1, exp_pass});
      end
      s_gold = gold;
   endtask

   task automatic test_start_busy();
      int nb;
      s_gold  = 16'h0008;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      nb = 0;
      for (int c = 0; c < 30; c++) begin
         if (!s_busy) break;
         nb++;
         s_start = (nb == 2 || nb == 3);
         @(negedge clk);
      end
      s_start = 1'b0;
      total++;
      if (nb !== 6) begin
         bad++;
         $display("FAIL start_busy_len got=%0d exp=6", nb);
      end
      total++;
      if ({s_done, s_pass, s_sig} !== {2'b11, 16'h0008}) begin
         bad++;
         $display("FAIL start_busy_sig got=%h exp=%h", {s_done, s_pass, s_sig}, {2'b11, 16'h0008});
      end
   endtask

   task automatic test_start_abort_done();
      s_start = 1'b1;
      s_abort = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      s_abort = 1'b0;
      total++;
      if ({s_busy, s_done, s_pass, s_sig, s_pat} !== {3'b000, 16'h0008, 5'b01001}) begin
         bad++;
         $display("FAIL start_abort_done got=%h exp=%h", {s_busy, s_done, s_pass, s_sig, s_pat}, {3'b000, 16'h0008, 5'b01001});
      end
      repeat (3) @(negedge clk);
      total++;
      if ({s_busy, s_cut, s_done, s_pat} !== {3'b000, 5'b01001}) begin
         bad++;
         $display("FAIL start_abort_norun got=%b exp=%b", {s_busy, s_cut, s_done, s_pat}, {3'b000, 5'b01001});
      end
   endtask

   task automatic test_abort_restart();
      s_gold  = 16'h0008;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      repeat (4) @(negedge clk);
      // now in the APPLY after the second CAPTURE
      total++;
      if ({s_busy, s_pat, s_sig} !== {1'b1, 5'b00100, 16'h0004}) begin
         bad++;
         $display("FAIL abort_pre got=%h exp=%h", {s_busy, s_pat, s_sig}, {1'b1, 5'b00100, 16'h0004});
      end
      s_abort = 1'b1;
      @(negedge clk);
      s_abort = 1'b0;
      total++;
      if ({s_busy, s_cut, s_done, s_pass, s_pat, s_sig} !== {4'b0000, 5'b00100, 16'h0004}) begin
         bad++;
         $display("FAIL abort_idle got=%h exp=%h", {s_busy, s_cut, s_done, s_pass, s_pat, s_sig}, {4'b0000, 5'b00100, 16'h0004});
      end
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      total++;
      if ({s_busy, s_sig, s_pat} !== {1'b1, 16'h0000, 5'b00001}) begin
         bad++;
         $display("FAIL restart_first got=%h exp=%h", {s_busy, s_sig, s_pat}, {1'b1, 16'h0000, 5'b00001});
      end
      for (int c = 0; c < 20 && !s_done; c++) @(negedge clk);
      total++;
      if ({s_done, s_pass, s_sig} !== {2'b11, 16'h0008}) begin
         bad++;
         $display("FAIL restart_final got=%h exp=%h", {s_done, s_pass, s_sig}, {2'b11, 16'h0008});
      end
   endtask

   task automatic test_wrap();
      int nb, distinct;
      logic [31:0] seen;
      logic zero;
      nb = 0; distinct = 0; seen = '0; zero = 1'b0;
      w_start = 1'b1;
      @(negedge clk);
      w_start = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (!w_busy) break;
         nb++;
         if (w_pat == 5'b00000) zero = 1'b1;
         if (!seen[w_pat]) begin
            seen[w_pat] = 1'b1;
            distinct++;
         end
         @(negedge clk);
      end
      total++;
      if (nb !== 93) begin
         bad++;
         $display("FAIL wrap_busy_len got=%0d exp=93", nb);
      end
      total++;
      if (distinct !== 31 || zero !== 1'b0) begin
         bad++;
         $display("FAIL wrap_distinct got=%0d zero=%b exp=31 zero=0", distinct, zero);
      end
      total++;
      if ({w_done, w_busy, w_pat} !== {2'b10, 5'b00001}) begin
         bad++;
         $display("FAIL wrap_done got=%b exp=%b", {w_done, w_busy, w_pat}, {2'b10, 5'b00001});
      end
   endtask

   task automatic test_async_reset();
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if ({s_pat, s_sig, s_busy, s_cut, s_done, s_pass} !== RST_VEC) begin
         bad++;
         $display("FAIL async_reset got=%h exp=%h", {s_pat, s_sig, s_busy, s_cut, s_done, s_pass}, RST_VEC);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ({s_busy, s_done} !== 2'b00) begin
         bad++;
         $display("FAIL async_reset_idle got=%b exp=00", {s_busy, s_done});
      end
   endtask

   initial begin
      test_reset();
      test_short(16'h0008, 1'b1);
      test_short(16'h0009, 1'b0);
      test_start_busy();
      test_start_abort_done();
      test_abort_restart();
      test_wrap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
